clock_rate_controller: RTL and testbench

Runtime-programmable clock-enable generator and rate sequencer for the board's slow-clock consumers (LED blinkers, scanners, debouncers). It owns one half-period counter and changes its rate without glitches: a new divide value is accepted over a valid/ready handshake and applied only at a period boundary. It also provides clean start and stop sequencing. It sits between the 12 MHz system clock domain and any logic that needs a slower toggle plus a one-cycle tick.

---
 rtl/clock_ctrl_pkg.sv | 14 +
 rtl/clock_rate_controller_half_period_counter.sv | 33 +++
 rtl/clock_rate_controller.sv | 128 ++++++++++++
 tb/tb_clock_rate_controller.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/clock_ctrl_pkg.sv
// Shared definitions for the clock-rate controller slice.
//   ctrl_state_t       : controller FSM state encoding
//   DEFAULT_HALF_12MHZ : half-period after reset (12 MHz / (2 * 600000) = 10 Hz)
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } ctrl_state_t;

    localparam logic [19:0] DEFAULT_HALF_12MHZ = 20'd600000;

endpackage

// File: rtl/clock_rate_controller_half_period_counter.sv
// Half-period counter: counts 0..H-1 and wraps to 0 on terminal count.
//   i_clock    : system clock
//   i_reset    : synchronous, active-high reset
//   i_clear    : hold the count at 0
//   i_enable   : advance the count this cycle
//   i_half     : active half-period H (never 0)
//   o_terminal : count == H-1
module half_period_counter #(
    parameter int unsigned WIDTH = 20
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_half,
    output logic             o_terminal
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    assign o_terminal = (r_count == (i_half - ONE));

    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= o_terminal ? '0 : r_count + ONE;
        end
    end

endmodule

// File: rtl/clock_rate_controller.sv
// Runtime-programmable clock-enable generator with glitch-free rate change.
//   i_clock     : system clock, rising edge
//   i_reset     : synchronous, active-high reset
//   i_enable    : 1 = run divided clock, 0 = stop at next period boundary
//   i_div_valid : new half-period offered
//   i_div_value : requested half-period in cycles (0 treated as 1)
//   o_div_ready : no change pending, a value can be accepted
//   o_clock     : registered divided clock, 50% duty
//   o_tick      : one-cycle pulse with each 0->1 edge of o_clock
//   o_busy      : controller not idle
module clock_rate_controller
    import clock_ctrl_pkg::*;
#(
    parameter int unsigned      WIDTH        = 20,
    parameter logic [WIDTH-1:0] DEFAULT_HALF = WIDTH'(DEFAULT_HALF_12MHZ)
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_div_valid,
    input  logic [WIDTH-1:0] i_div_value,
    output logic             o_div_ready,
    output logic             o_clock,
    output logic             o_tick,
    output logic             o_busy
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    ctrl_state_t      r_state;
    logic [WIDTH-1:0] r_half;
    logic [WIDTH-1:0] r_pend_val;
    logic             r_pend;
    logic             r_clock;
    logic             r_tick;

    ctrl_state_t      w_next_state;
    logic             w_clock_next;
    logic             w_tick_next;
    logic             w_apply;
    logic             w_accept;
    logic             w_terminal;

    half_period_counter #(.WIDTH(WIDTH)) u_counter (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_clear    (r_state == ST_IDLE),
        .i_enable   (r_state != ST_IDLE),
        .i_half     (r_half),
        .o_terminal (w_terminal)
    );

    assign w_accept    = i_div_valid && !r_pend;
    assign o_div_ready = !r_pend;
    assign o_clock     = r_clock;
    assign o_tick      = r_tick;
    assign o_busy      = (r_state != ST_IDLE);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A disabled controller stops at whichever boundary comes first: a
    // falling edge, or the end of a low phase (suppressing that rise).
    always_comb begin
        w_next_state = r_state;
        w_clock_next = r_clock;
        w_tick_next  = 1'b0;
        w_apply      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_clock_next = 1'b0;
                w_apply      = r_pend;
                if (i_enable) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN, ST_STOPPING: begin
                if (w_terminal) begin
                    if (!i_enable) begin
                        w_next_state = ST_IDLE;
                        w_clock_next = 1'b0;
                        w_apply      = r_pend;
                    end else begin
                        w_next_state = ST_RUN;
                        w_clock_next = !r_clock;
                        w_tick_next  = !r_clock;
                        w_apply      = r_clock && r_pend;
                    end
                end else begin
                    w_next_state = i_enable ? ST_RUN : ST_STOPPING;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_clock_next = 1'b0;
            end
        endcase
    end

    // Apply and accept are mutually exclusive: apply needs a pending value,
    // accept needs none.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_half     <= DEFAULT_HALF;
            r_pend_val <= '0;
            r_pend     <= 1'b0;
            r_clock    <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            r_clock <= w_clock_next;
            r_tick  <= w_tick_next;
            if (w_apply) begin
                r_half <= r_pend_val;
                r_pend <= 1'b0;
            end
            if (w_accept) begin
                r_pend_val <= (i_div_value == '0) ? ONE : i_div_value;
                r_pend     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clock_rate_controller.sv
module tb_clock_rate_controller;

    localparam int unsigned W  = 20;
    localparam int unsigned DH = 7;

    logic         clk  = 1'b0;
    logic         rst  = 1'b1;
    logic         en   = 1'b0;
    logic         dv   = 1'b0;
    logic [W-1:0] dval = '0;
    logic         o_div_ready, o_clock, o_tick, o_busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    clock_rate_controller #(
        .WIDTH        (W),
        .DEFAULT_HALF (W'(DH))
    ) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_enable    (en),
        .i_div_valid (dv),
        .i_div_value (dval),
        .o_div_ready (o_div_ready),
        .o_clock     (o_clock),
        .o_tick      (o_tick),
        .o_busy      (o_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phases of H edges, level flips at each phase end.
    int unsigned m_half    = DH;
    int unsigned m_pval    = 0;
    int unsigned m_elapsed = 0;
    bit          m_pend    = 0;
    bit          m_busy    = 0;
    bit          m_level   = 0;
    bit          m_tick    = 0;
    bit          m_live    = 0;
    bit          m_acc;

    always @(posedge clk) begin
        m_acc = dv && !m_pend;
        if (rst) begin
            m_half = DH; m_pend = 0; m_busy = 0; m_level = 0; m_tick = 0;
            m_elapsed = 0; m_live = 1;
        end else begin
            m_tick = 0;
            if (!m_busy) begin
                if (m_pend) begin m_half = m_pval; m_pend = 0; end
                m_level = 0;
                if (en) begin m_busy = 1; m_elapsed = 0; end
            end else begin
                m_elapsed++;
                if (m_elapsed == m_half) begin
                    m_elapsed = 0;
                    if (!en) begin
                        m_busy = 0; m_level = 0;
                        if (m_pend) begin m_half = m_pval; m_pend = 0; end
                    end else if (!m_level) begin
                        m_level = 1; m_tick = 1;
                    end else begin
                        m_level = 0;
                        if (m_pend) begin m_half = m_pval; m_pend = 0; end
                    end
                end
            end
            if (m_acc) begin
                m_pend = 1;
                m_pval = (dval == '0) ? 1 : int'(dval);
            end
        end
        #1;
        if (m_live) begin
            check("model_clock", o_clock, m_level);
            check("model_tick", o_tick, m_tick);
            check("model_ready", o_div_ready, !m_pend);
            check("model_busy", o_busy, m_busy);
        end
    end

    task automatic cyc(input bit r, input bit e, input bit v, input logic [W-1:0] d);
        rst = r; en = e; dv = v; dval = d;
        @(posedge clk);
        #2;
    endtask

    logic [15:0] s_clk, s_tick, s_aux;
    bit          r_en;

    initial begin
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("reset_clock", o_clock, 0);
        check("reset_tick", o_tick, 0);
        check("reset_ready", o_div_ready, 1);
        check("reset_busy", o_busy, 0);

        // H=3 written in IDLE, then run
        cyc(0, 0, 1, 3);
        check("idle_accept_ready", o_div_ready, 0);
        cyc(0, 0, 0, 0);
        check("idle_apply_ready", o_div_ready, 1);
        s_clk = '0; s_tick = '0;
        for (int e = 0; e < 12; e++) begin
            cyc(0, 1, 0, 0);
            s_clk[e] = o_clock; s_tick[e] = o_tick;
            if (e == 0) check("run_busy", o_busy, 1);
        end
        check("h3_clock_seq", s_clk, 16'h0E38);
        check("h3_tick_seq", s_tick, 16'h0208);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0);
        check("h3_stopped", o_busy, 0);

        // H=4, change to 2 mid-high; second offer while pending ignored
        cyc(0, 0, 1, 4);
        cyc(0, 0, 0, 0);
        s_clk = '0; s_aux = '0;
        for (int e = 0; e < 16; e++) begin
            cyc(0, 1, (e == 6) || (e == 7), (e == 6) ? W'(2) : W'(9));
            s_clk[e] = o_clock; s_aux[e] = o_div_ready;
        end
        check("rate_change_clock_seq", s_clk, 16'hCCF0);
        check("rate_change_ready_seq", s_aux, 16'hFF3F);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0);
        check("h2_stopped", o_busy, 0);

        // H=5, drop enable one cycle after a rise
        cyc(0, 0, 1, 5);
        cyc(0, 0, 0, 0);
        s_clk = '0; s_tick = '0; s_aux = '0;
        for (int e = 0; e < 16; e++) begin
            cyc(0, e <= 5, 0, 0);
            s_clk[e] = o_clock; s_tick[e] = o_tick; s_aux[e] = o_busy;
        end
        check("stop_clock_seq", s_clk, 16'h03E0);
        check("stop_tick_seq", s_tick, 16'h0020);
        check("stop_busy_seq", s_aux, 16'h03FF);

        // value 0 -> H=1, period 2
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        s_clk = '0; s_tick = '0;
        for (int e = 0; e < 8; e++) begin
            cyc(0, 1, 0, 0);
            s_clk[e] = o_clock; s_tick[e] = o_tick;
        end
        check("h1_clock_seq", s_clk, 16'h00AA);
        check("h1_tick_seq", s_tick, 16'h00AA);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
        check("h1_stopped", o_busy, 0);

        // reset during high phase with a pending change
        cyc(0, 0, 1, 3);
        cyc(0, 0, 0, 0);
        for (int e = 0; e < 5; e++) cyc(0, 1, e == 4, 6);
        check("pre_reset_clock", o_clock, 1);
        check("pre_reset_ready", o_div_ready, 0);
        cyc(1, 1, 0, 0);
        check("mid_reset_clock", o_clock, 0);
        check("mid_reset_ready", o_div_ready, 1);
        check("mid_reset_busy", o_busy, 0);
        check("mid_reset_tick", o_tick, 0);
        s_clk = '0; s_tick = '0;
        for (int e = 0; e < 9; e++) begin
            cyc(0, 1, 0, 0);
            s_clk[e] = o_clock; s_tick[e] = o_tick;
        end
        check("default_half_clock_seq", s_clk, 16'h0180);
        check("default_half_tick_seq", s_tick, 16'h0080);

        // random soak against the model
        r_en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) r_en = !r_en;
            cyc($urandom_range(0, 149) == 0, r_en, $urandom_range(0, 3) == 0,
                W'($urandom_range(0, 5)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
